// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate zero/sign/upper extender with a DEPTH-entry result FIFO; IMM_EXTEND_LUI_EN enables the upper (LUI) mode
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_imm,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int PAD_W = OUT_W - IN_W;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  localparam logic [1:0] MODE_ZERO  = 2'b00;
  localparam logic [1:0] MODE_SIGN  = 2'b01;
`ifdef IMM_EXTEND_LUI_EN
  localparam logic [1:0] MODE_UPPER = 2'b10;
`endif

  logic [OUT_W-1:0] data_mem [DEPTH];
  logic             err_mem  [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic             push;
  logic             pop;

  // Handshake flags come straight from the registered count, so a pop at
  // full cannot open a slot for a push in the same cycle.
  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign occupancy = count;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head entry is read from storage; nothing computed this cycle bypasses to the output.
  assign out_data  = data_mem[rd_ptr];
  assign out_err   = err_mem[rd_ptr];

  // Extend the incoming immediate; any mode without a legal meaning stores zero with the error flag.
  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (in_mode)
      MODE_ZERO:  ext_data = {{PAD_W{1'b0}}, in_imm};
      MODE_SIGN:  ext_data = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
`ifdef IMM_EXTEND_LUI_EN
      MODE_UPPER: ext_data = {in_imm, {PAD_W{1'b0}}};
`endif
      default:    ext_err  = 1'b1;
    endcase
  end

  // FIFO state: reset clears every entry so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        err_mem[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= ext_data;
        err_mem[wr_ptr]  <= ext_err;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
